// File: rtl/painterengine_gpu_pkg.sv
// Shared definitions for the PainterEngine GPU DMA writer:
// FSM state encoding, error codes and beat-size helpers.
package painterengine_gpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_CALC  = 3'd2,
        ST_AW    = 3'd3,
        ST_W     = 3'd4,
        ST_B     = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERROR = 3'd7
    } writer_state_t;

    localparam logic [2:0] ERR_NONE    = 3'b000;
    localparam logic [2:0] ERR_ROUTER  = 3'b001;
    localparam logic [2:0] ERR_PARAM   = 3'b010;
    localparam logic [2:0] ERR_BRESP   = 3'b011;
    localparam logic [2:0] ERR_TIMEOUT = 3'b100;

    localparam int unsigned PAGE_BYTES = 4096;

    function automatic int unsigned bytes_per_beat(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned log2_floor(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((value >> i) != 0) begin
                result = i;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/painterengine_gpu_burst_calc.sv
// Burst sizing for the DMA writer: registers the next burst length
// min(remaining, MAX_BURST, beats left in the 4 KB page) and its address.
module painterengine_gpu_burst_calc
    import painterengine_gpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic        i_wire_calc,
    input  logic [31:0] i_wire_base,
    input  logic [31:0] i_wire_offset,
    input  logic [31:0] i_wire_length,
    output logic [8:0]  o_wire_burst,
    output logic [7:0]  o_wire_awlen,
    output logic [31:0] o_wire_awaddr
);

    localparam int unsigned BYTES = bytes_per_beat(DATA_WIDTH);
    localparam int unsigned LOG2B = log2_floor(BYTES);

    logic [31:0] cur_addr;
    logic [31:0] beats_4k;
    logic [31:0] remaining;
    logic [31:0] pick;
    logic        unused_pick_hi;

    // Current address and the smallest of the three burst limits
    always_comb begin
        cur_addr  = i_wire_base + (i_wire_offset << LOG2B);
        beats_4k  = (32'(PAGE_BYTES) - {20'd0, cur_addr[11:0]}) >> LOG2B;
        remaining = i_wire_length - i_wire_offset;
        pick      = remaining;
        if (pick > 32'(MAX_BURST)) begin
            pick = 32'(MAX_BURST);
        end
        if (pick > beats_4k) begin
            pick = beats_4k;
        end
    end

    // Burst never exceeds 256, so the upper bits of the minimum are always zero
    assign unused_pick_hi = |pick[31:9];

    // Capture the burst parameters during the single CALC cycle
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            o_wire_burst  <= '0;
            o_wire_awlen  <= '0;
            o_wire_awaddr <= '0;
        end else if (i_wire_calc) begin
            o_wire_burst  <= pick[8:0];
            // pick is 1..256; 256 wraps to 0 in 8 bits and minus one gives 255
            o_wire_awlen  <= pick[7:0] - 8'd1;
            o_wire_awaddr <= cur_addr;
        end
    end

endmodule

// File: rtl/painterengine_gpu_dma_writer_mc.sv
// Multi-channel AXI4 burst DMA writer. One stream source is routed per job
// and written from a start address for a beat count, split at MAX_BURST
// and at 4 KB boundaries. Optional stall timeout: PE_GPU_WRITER_TIMEOUT_EN.
module painterengine_gpu_dma_writer_mc
    import painterengine_gpu_pkg::*;
#(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                           i_wire_clock,
    input  logic                           i_wire_resetn,
    input  logic                           i_wire_start,
    input  logic                           i_wire_clear,
    input  logic [CHANNELS-1:0]            i_wire_router,
    input  logic [32*CHANNELS-1:0]         i_wire_address,
    input  logic [32*CHANNELS-1:0]         i_wire_length,
    input  logic [DATA_WIDTH*CHANNELS-1:0] i_wire_data,
    input  logic [CHANNELS-1:0]            i_wire_data_valid,
    output logic [CHANNELS-1:0]            o_wire_data_next,
    output logic                           o_wire_busy,
    output logic                           o_wire_done,
    output logic                           o_wire_error,
    output logic [2:0]                     o_wire_error_type,
    output logic [31:0]                    o_wire_M_AXI_AWADDR,
    output logic [7:0]                     o_wire_M_AXI_AWLEN,
    output logic [2:0]                     o_wire_M_AXI_AWSIZE,
    output logic [1:0]                     o_wire_M_AXI_AWBURST,
    output logic                           o_wire_M_AXI_AWVALID,
    input  logic                           i_wire_M_AXI_AWREADY,
    output logic                           o_wire_M_AXI_AWID,
    output logic                           o_wire_M_AXI_AWLOCK,
    output logic [3:0]                     o_wire_M_AXI_AWCACHE,
    output logic [2:0]                     o_wire_M_AXI_AWPROT,
    output logic [3:0]                     o_wire_M_AXI_AWQOS,
    output logic [DATA_WIDTH-1:0]          o_wire_M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]        o_wire_M_AXI_WSTRB,
    output logic                           o_wire_M_AXI_WLAST,
    output logic                           o_wire_M_AXI_WVALID,
    input  logic                           i_wire_M_AXI_WREADY,
    input  logic                           i_wire_M_AXI_BID,
    input  logic [1:0]                     i_wire_M_AXI_BRESP,
    input  logic                           i_wire_M_AXI_BVALID,
    output logic                           o_wire_M_AXI_BREADY
);

    localparam int unsigned BYTES      = bytes_per_beat(DATA_WIDTH);
    localparam int unsigned LOG2B      = log2_floor(BYTES);
    localparam int unsigned SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);

    writer_state_t        state_q;
    writer_state_t        state_n;
    logic [2:0]           err_q;
    logic [2:0]           err_n;

    logic [CHANNELS-1:0]  router_q;
    logic [31:0]          base_q;
    logic [31:0]          len_q;
    logic [SEL_W-1:0]     sel_q;
    logic [31:0]          offset_q;
    logic [8:0]           beat_q;

    logic [31:0]          addr_mux;
    logic [31:0]          len_mux;
    logic [SEL_W-1:0]     sel_mux;

    logic [8:0]           burst;
    logic [7:0]           burst_awlen;
    logic [31:0]          burst_awaddr;

    logic                 start_ok;
    logic                 in_xfer;
    logic                 wvalid_c;
    logic                 wlast_c;
    logic                 aw_hs;
    logic                 w_hs;
    logic                 b_hs;
    logic                 stall_expired;
    logic                 unused_ok;

    // Route the requested channel's job parameters for latching at start
    always_comb begin
        addr_mux = '0;
        len_mux  = '0;
        sel_mux  = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (i_wire_router[i]) begin
                addr_mux = addr_mux | i_wire_address[32*i +: 32];
                len_mux  = len_mux | i_wire_length[32*i +: 32];
                sel_mux  = SEL_W'(i);
            end
        end
    end

    assign start_ok = (state_q == ST_IDLE) && i_wire_start;
    assign in_xfer  = (state_q == ST_AW) || (state_q == ST_W) || (state_q == ST_B);
    assign wvalid_c = (state_q == ST_W) && i_wire_data_valid[sel_q];
    assign wlast_c  = wvalid_c && (beat_q == (burst - 9'd1));
    assign aw_hs    = (state_q == ST_AW) && i_wire_M_AXI_AWREADY;
    assign w_hs     = wvalid_c && i_wire_M_AXI_WREADY;
    assign b_hs     = (state_q == ST_B) && i_wire_M_AXI_BVALID;

    painterengine_gpu_burst_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_burst_calc (
        .i_wire_clock  (i_wire_clock),
        .i_wire_resetn (i_wire_resetn),
        .i_wire_calc   (state_q == ST_CALC),
        .i_wire_base   (base_q),
        .i_wire_offset (offset_q),
        .i_wire_length (len_q),
        .o_wire_burst  (burst),
        .o_wire_awlen  (burst_awlen),
        .o_wire_awaddr (burst_awaddr)
    );

`ifdef PE_GPU_WRITER_TIMEOUT_EN
    logic [15:0] stall_q;

    // Count consecutive cycles without progress on the AXI channels
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            stall_q <= '0;
        end else if (!in_xfer || aw_hs || w_hs || b_hs) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_expired = in_xfer && !(aw_hs || w_hs || b_hs) &&
                           (stall_q == 16'(TIMEOUT_CYCLES - 1));
    assign unused_ok     = &{1'b0, i_wire_M_AXI_BID, i_wire_M_AXI_BRESP[0]};
`else
    assign stall_expired = 1'b0;
    assign unused_ok     = &{1'b0, i_wire_M_AXI_BID, i_wire_M_AXI_BRESP[0],
                             (TIMEOUT_CYCLES != 0), (ERR_TIMEOUT != ERR_NONE)};
`endif

    // State and sticky error-code register
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_n;
            err_q   <= err_n;
        end
    end

    // Next-state and error-code selection
    always_comb begin
        state_n = state_q;
        err_n   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (i_wire_start) begin
                    state_n = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!$onehot(router_q)) begin
                    state_n = ST_ERROR;
                    err_n   = ERR_ROUTER;
                end else if (((base_q & ALIGN_MASK) != '0) || (len_q == '0)) begin
                    state_n = ST_ERROR;
                    err_n   = ERR_PARAM;
                end else begin
                    state_n = ST_CALC;
                end
            end
            ST_CALC: begin
                state_n = ST_AW;
            end
            ST_AW: begin
                if (aw_hs) begin
                    state_n = ST_W;
                end
            end
            ST_W: begin
                if (w_hs && wlast_c) begin
                    state_n = ST_B;
                end
            end
            ST_B: begin
                if (b_hs) begin
                    if (i_wire_M_AXI_BRESP[1]) begin
                        state_n = ST_ERROR;
                        err_n   = ERR_BRESP;
                    end else if (offset_q < len_q) begin
                        state_n = ST_CALC;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (i_wire_clear) begin
                    state_n = ST_IDLE;
                    err_n   = ERR_NONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                err_n   = ERR_NONE;
            end
        endcase
        if (stall_expired) begin
            state_n = ST_ERROR;
            err_n   = ERR_TIMEOUT;
        end
    end

    // Job latch at start, beat counter within a burst, beat offset within the job
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            router_q <= '0;
            base_q   <= '0;
            len_q    <= '0;
            sel_q    <= '0;
            offset_q <= '0;
            beat_q   <= '0;
        end else begin
            if (start_ok) begin
                router_q <= i_wire_router;
                base_q   <= addr_mux;
                len_q    <= len_mux;
                sel_q    <= sel_mux;
                offset_q <= '0;
            end
            if (aw_hs) begin
                beat_q <= '0;
            end
            if (w_hs) begin
                if (wlast_c) begin
                    beat_q   <= '0;
                    offset_q <= offset_q + 32'(burst);
                end else begin
                    beat_q <= beat_q + 9'd1;
                end
            end
        end
    end

    // Status and AXI outputs decoded from the current state
    always_comb begin
        o_wire_busy          = !((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                 (state_q == ST_ERROR));
        o_wire_done          = (state_q == ST_DONE);
        o_wire_error         = (state_q == ST_ERROR);
        o_wire_error_type    = (state_q == ST_ERROR) ? err_q : ERR_NONE;
        o_wire_M_AXI_AWADDR  = burst_awaddr;
        o_wire_M_AXI_AWLEN   = burst_awlen;
        o_wire_M_AXI_AWVALID = (state_q == ST_AW);
        o_wire_M_AXI_WVALID  = wvalid_c;
        o_wire_M_AXI_WLAST   = wlast_c;
        o_wire_M_AXI_WDATA   = (state_q == ST_W) ?
                               i_wire_data[sel_q*DATA_WIDTH +: DATA_WIDTH] : '0;
        o_wire_M_AXI_BREADY  = (state_q == ST_B);
        o_wire_data_next     = '0;
        if (w_hs) begin
            o_wire_data_next[sel_q] = 1'b1;
        end
    end

    assign o_wire_M_AXI_AWSIZE  = 3'(LOG2B);
    assign o_wire_M_AXI_AWBURST = 2'b01;
    assign o_wire_M_AXI_WSTRB   = '1;
    assign o_wire_M_AXI_AWID    = 1'b0;
    assign o_wire_M_AXI_AWLOCK  = 1'b0;
    assign o_wire_M_AXI_AWCACHE = 4'b0010;
    assign o_wire_M_AXI_AWPROT  = 3'b000;
    assign o_wire_M_AXI_AWQOS   = 4'b0000;

endmodule

// File: tb/tb_painterengine_gpu_dma_writer_mc.sv
// Self-checking bench for painterengine_gpu_dma_writer_mc (4 channels, 32-bit, bursts of 16).
module tb_painterengine_gpu_dma_writer_mc;

    localparam int unsigned CH   = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXB = 16;
    localparam int unsigned TMO  = 100;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              clear = 1'b0;
    logic [CH-1:0]     router = '0;
    logic [32*CH-1:0]  address = '0;
    logic [32*CH-1:0]  length = '0;
    logic [DW*CH-1:0]  data = '0;
    logic [CH-1:0]     dvalid = '0;
    logic [CH-1:0]     data_next;
    logic              busy, done, error;
    logic [2:0]        error_type;
    logic [31:0]       awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready = 1'b0;
    logic              awid, awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic [3:0]        awqos;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wlast, wvalid;
    logic              wready = 1'b0;
    logic              bid = 1'b0;
    logic [1:0]        bresp = 2'b00;
    logic              bvalid = 1'b0;
    logic              bready;

    painterengine_gpu_dma_writer_mc #(
        .CHANNELS       (CH),
        .DATA_WIDTH     (DW),
        .MAX_BURST      (MAXB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_wire_clock         (clk),
        .i_wire_resetn        (resetn),
        .i_wire_start         (start),
        .i_wire_clear         (clear),
        .i_wire_router        (router),
        .i_wire_address       (address),
        .i_wire_length        (length),
        .i_wire_data          (data),
        .i_wire_data_valid    (dvalid),
        .o_wire_data_next     (data_next),
        .o_wire_busy          (busy),
        .o_wire_done          (done),
        .o_wire_error         (error),
        .o_wire_error_type    (error_type),
        .o_wire_M_AXI_AWADDR  (awaddr),
        .o_wire_M_AXI_AWLEN   (awlen),
        .o_wire_M_AXI_AWSIZE  (awsize),
        .o_wire_M_AXI_AWBURST (awburst),
        .o_wire_M_AXI_AWVALID (awvalid),
        .i_wire_M_AXI_AWREADY (awready),
        .o_wire_M_AXI_AWID    (awid),
        .o_wire_M_AXI_AWLOCK  (awlock),
        .o_wire_M_AXI_AWCACHE (awcache),
        .o_wire_M_AXI_AWPROT  (awprot),
        .o_wire_M_AXI_AWQOS   (awqos),
        .o_wire_M_AXI_WDATA   (wdata),
        .o_wire_M_AXI_WSTRB   (wstrb),
        .o_wire_M_AXI_WLAST   (wlast),
        .o_wire_M_AXI_WVALID  (wvalid),
        .i_wire_M_AXI_WREADY  (wready),
        .i_wire_M_AXI_BID     (bid),
        .i_wire_M_AXI_BRESP   (bresp),
        .i_wire_M_AXI_BVALID  (bvalid),
        .o_wire_M_AXI_BREADY  (bready)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Bus/producer state shared between the bus process and the main sequence
    int unsigned pidx [CH];
    logic        rnd = 1'b0;
    logic        b_never = 1'b0;
    int          b_pending = 0;
    int          b_idx = 0;
    int          bad_burst = -1;
    int          cur_ch = 0;
    int          dn_sel = 0;
    int          dn_other = 0;
    int          b_stall = 0;
    int unsigned job_p0 = 0;
    logic [31:0] mon_awaddr [$];
    logic [7:0]  mon_awlen [$];
    logic [31:0] mon_wdata [$];
    logic        mon_wlast [$];
    logic [31:0] exp_addr [$];
    int unsigned exp_beats [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_word(input int unsigned ch, input int unsigned idx);
        return {4'(ch), 4'hA, 24'(idx)};
    endfunction

    // Reference split: each burst is as long as allowed by remaining beats,
    // the burst cap and the room left in the current 4 KB page
    task automatic model_bursts(input logic [31:0] a, input int unsigned len);
        int unsigned sent, rem, room, b;
        logic [31:0] cur;
        exp_addr.delete();
        exp_beats.delete();
        sent = 0;
        while (sent < len) begin
            cur  = a + 32'(sent * 4);
            rem  = len - sent;
            room = (4096 - (cur % 4096)) / 4;
            b    = rem;
            if (b > MAXB) b = MAXB;
            if (b > room) b = room;
            exp_addr.push_back(cur);
            exp_beats.push_back(b);
            sent += b;
        end
    endtask

    // Memory-side responder and stream producer; samples 1 time unit before each rising edge
    initial begin
        for (int i = 0; i < CH; i++) pidx[i] = 0;
        forever begin
            @(negedge clk);
            awready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            wready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            for (int i = 0; i < CH; i++) begin
                data[DW*i +: DW] = beat_word(i, pidx[i]);
                dvalid[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            bvalid = (b_pending > 0) && !b_never && (rnd ? ($urandom_range(0, 1) != 0) : 1'b1);
            bresp  = (b_idx == bad_burst) ? 2'b10 : 2'b00;
            #4;
            if (awvalid && awready) begin
                mon_awaddr.push_back(awaddr);
                mon_awlen.push_back(awlen);
            end
            if (wvalid && wready) begin
                mon_wdata.push_back(wdata);
                mon_wlast.push_back(wlast);
                if (wlast) b_pending++;
            end
            for (int i = 0; i < CH; i++) begin
                if (data_next[i]) begin
                    pidx[i]++;
                    if (i == cur_ch) dn_sel++;
                    else dn_other++;
                end
            end
            if (bready && !bvalid) b_stall++;
            if (bvalid && bready) begin
                b_pending--;
                b_idx++;
            end
        end
    end

    task automatic start_job(input logic [CH-1:0] rt, input int ch, input logic [31:0] a,
                             input int unsigned len, input bit scramble);
        for (int i = 0; i < CH; i++) begin
            address[32*i +: 32] = $urandom & 32'hFFFF_FFFC;
            length[32*i +: 32]  = 32'($urandom_range(1, 100));
        end
        address[32*ch +: 32] = a;
        length[32*ch +: 32]  = len;
        router = rt;
        cur_ch = ch;
        mon_awaddr.delete();
        mon_awlen.delete();
        mon_wdata.delete();
        mon_wlast.delete();
        dn_sel = 0;
        dn_other = 0;
        b_idx = 0;
        b_stall = 0;
        job_p0 = pidx[ch];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (scramble) begin
            router = 4'($urandom);
            for (int i = 0; i < CH; i++) begin
                address[32*i +: 32] = $urandom;
                length[32*i +: 32]  = $urandom;
            end
        end
    endtask

    task automatic wait_job();
        bit ended;
        ended = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (done || error) begin
                ended = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("job_end_within_budget", ended, 1'b1);
    endtask

    task automatic run_job(input logic [CH-1:0] rt, input int ch, input logic [31:0] a,
                           input int unsigned len, input bit scramble);
        start_job(rt, ch, a, len, scramble);
        wait_job();
    endtask

    task automatic check_transfer(input int ch, input logic [31:0] a, input int unsigned len);
        int unsigned n, acc, bi;
        logic exp_last;
        model_bursts(a, len);
        check("burst_count", mon_awaddr.size(), exp_addr.size());
        n = (mon_awaddr.size() < exp_addr.size()) ? mon_awaddr.size() : exp_addr.size();
        for (int unsigned k = 0; k < n; k++) begin
            check("aw_addr", mon_awaddr[k], exp_addr[k]);
            check("aw_len", mon_awlen[k], exp_beats[k] - 1);
            check("no_4k_cross", ((mon_awaddr[k] % 4096) + (mon_awlen[k] + 1) * 4) <= 4096, 1'b1);
        end
        check("beat_count", mon_wdata.size(), len);
        n = (mon_wdata.size() < len) ? mon_wdata.size() : len;
        acc = 0;
        bi  = 0;
        for (int unsigned k = 0; k < n; k++) begin
            exp_last = (bi < exp_beats.size()) && (k == acc + exp_beats[bi] - 1);
            if (exp_last) begin
                acc += exp_beats[bi];
                bi++;
            end
            check("wdata_order", mon_wdata[k], beat_word(ch, job_p0 + k));
            check("wlast", mon_wlast[k], exp_last);
        end
        check("data_next_sel", dn_sel, len);
        check("data_next_other", dn_other, 0);
        check("done", done, 1'b1);
        check("busy_after_done", busy, 1'b0);
        check("error_after_done", error, 1'b0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear_busy", busy, 1'b0);
        check("clear_done", done, 1'b0);
        check("clear_error", error, 1'b0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CH-1:0] rt;
        logic [31:0]   a;
        int            ch;
        int unsigned   len;
        bit            found;

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_error_type", error_type, 3'b000);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_data_next", data_next, 4'b0000);
        check("rst_awaddr", awaddr, 32'h0);
        check("rst_awlen", awlen, 8'h0);
        check("rst_awsize", awsize, 3'd2);
        check("rst_awburst", awburst, 2'b01);
        check("rst_wstrb", wstrb, 4'hF);
        check("rst_awcache", awcache, 4'b0010);
        check("rst_aw_consts", {awid, awlock, awprot, awqos}, 9'h0);
        check("rst_wlast", wlast, 1'b0);
        check("rst_wdata", wdata, 32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Channel 2, 40 beats from 0x1000: 16,16,8
        rnd = 1'b0;
        run_job(4'b0100, 2, 32'h1000, 40, 1'b0);
        check_transfer(2, 32'h1000, 40);

        // start in DONE is ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("start_ignored_in_done", {done, busy}, 2'b10);
        do_clear();

        // 4 KB split: 2 beats at 0x0FF8 then 6 at 0x1000
        run_job(4'b0010, 1, 32'h0FF8, 8, 1'b0);
        check_transfer(1, 32'h0FF8, 8);
        do_clear();

        // Router not one-hot
        run_job(4'b0110, 1, 32'h1000, 8, 1'b0);
        check("router_err", error, 1'b1);
        check("router_err_type", error_type, 3'b001);
        check("router_err_no_aw", mon_awaddr.size(), 0);
        do_clear();

        // Misaligned address, zero length
        run_job(4'b0001, 0, 32'h1002, 8, 1'b0);
        check("align_err_type", error_type, 3'b010);
        do_clear();
        run_job(4'b1000, 3, 32'h2000, 0, 1'b0);
        check("len0_err_type", error_type, 3'b010);
        do_clear();

        // Random back-pressure and stream gaps; inputs scrambled after start
        rnd = 1'b1;
        for (int it = 0; it < 8; it++) begin
            ch  = int'($urandom_range(0, CH - 1));
            a   = 32'(32'h0001_0000 * $urandom_range(0, 3) + 32'h1000 * $urandom_range(1, 4)
                      - 4 * $urandom_range(0, 40));
            len = $urandom_range(1, 70);
            rt  = '0;
            rt[ch] = 1'b1;
            run_job(rt, ch, a, len, 1'b1);
            check_transfer(ch, a, len);
            do_clear();
        end

        // SLVERR on the second burst
        rnd = 1'b0;
        bad_burst = 1;
        run_job(4'b0100, 2, 32'h2000, 40, 1'b0);
        check("bresp_err", error, 1'b1);
        check("bresp_err_type", error_type, 3'b011);
        check("bresp_err_bursts", mon_awaddr.size(), 2);
        check("bresp_err_beats", dn_sel, 32);
        bad_burst = -1;
        do_clear();

        // No write response at all
        b_never = 1'b1;
`ifdef PE_GPU_WRITER_TIMEOUT_EN
        run_job(4'b0001, 0, 32'h4000, 4, 1'b0);
        check("timeout_err_type", error_type, 3'b100);
        check("timeout_b_cycles", b_stall, TMO);
        b_never = 1'b0;
        b_pending = 0;
        do_clear();
`else
        start_job(4'b0001, 0, 32'h4000, 4, 1'b0);
        repeat (300) @(posedge clk);
        #1;
        check("no_timeout_still_busy", {busy, bready, error}, 3'b110);
        resetn = 1'b0;
        #1;
        check("no_timeout_reset_idle", {busy, bready}, 2'b00);
        b_never = 1'b0;
        b_pending = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
`endif

        // Reset while writing data: valids drop without waiting for a clock
        rnd = 1'b1;
        start_job(4'b0001, 0, 32'h3000, 60, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (wvalid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("reached_w_state", found, 1'b1);
        #1;
        resetn = 1'b0;
        #1;
        check("async_rst_awvalid", awvalid, 1'b0);
        check("async_rst_wvalid", wvalid, 1'b0);
        check("async_rst_bready", bready, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        b_pending = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        rnd = 1'b0;
        run_job(4'b1000, 3, 32'h3000, 20, 1'b0);
        check_transfer(3, 32'h3000, 20);
        do_clear();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
